// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        RELEASE_DB
    } kp_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } frame_res_t;

    // Per-frame accumulator: saturating hit count (0, 1, 2+) and the code of the first hit.
    typedef struct packed {
        logic [1:0] hits;
        logic [3:0] code;
    } frame_acc_t;

    // Number of rows pulled low in one column sample (0..4).
    function automatic logic [2:0] count_low(input logic [3:0] low);
        count_low = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column scanner: drives one keypad column low at a time, dwelling SCAN_DIV cycles on each.
// Latency: tick is combinational on the last dwell cycle; col_out changes the cycle after tick.
// Backpressure: none, free-running.
//
// Ports:
//   clk_in, rst        clock and synchronous active-high reset
//   col_out[3:0]       active-low one-hot column drive
//   col_idx[1:0]       index of the column currently driven
//   tick               last dwell cycle of the current column (sample point)
//   frame_end          tick on column 3, i.e. the last sample of a frame
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100,
    parameter int CNT_W    = 7
) (
    input  logic       clk_in,
    input  logic       rst,
    output logic [3:0] col_out,
    output logic [1:0] col_idx,
    output logic       tick,
    output logic       frame_end
);

    logic [CNT_W-1:0] dwell_cnt;

    assign tick      = (dwell_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = tick && (col_idx == 2'(NUM_COLS - 1));
    assign col_out   = ~(4'b0001 << col_idx);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
        end else if (tick) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: debounced press/release, one key_valid pulse per accepted press.
// Latency: key_valid 1 cycle after the frame-end tick of the DEBOUNCE-th matching frame.
// Backpressure: none; key_valid is a one-cycle pulse with no handshake, key_code holds until next press.
//
// Ports:
//   clk_in, rst        clock and synchronous active-high reset
//   row_in[3:0]        keypad rows, active-low, asynchronous
//   col_out[3:0]       active-low one-hot column drive
//   key_code[3:0]      last accepted key, row*4 + col
//   key_valid          one-cycle pulse on accepted press
//   key_held           high while the accepted key is considered down
module keypad4x4_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 7
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic [1:0] col_idx;
    logic       tick;
    logic       frame_end;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_col_scan (
        .clk_in    (clk_in),
        .rst       (rst),
        .col_out   (col_out),
        .col_idx   (col_idx),
        .tick      (tick),
        .frame_end (frame_end)
    );

    // Two-flop synchronizer; idle rows read high.
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Merge the current column sample into the frame accumulator.
    frame_acc_t acc;
    logic [3:0] col_low;
    logic [2:0] col_hits;
    logic [2:0] tot_hits;
    logic [1:0] first_row;
    logic [1:0] sat_hits;
    logic [3:0] merged_code;
    frame_res_t frame_res;

    assign col_low  = ~row_sync;
    assign col_hits = count_low(col_low);
    assign tot_hits = {1'b0, acc.hits} + col_hits;
    assign sat_hits = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];

    always_comb begin
        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (col_low[r]) begin
                first_row = 2'(r);
            end
        end
    end

    // The first hit of the frame wins; later hits only push the count to MULTI.
    assign merged_code = (acc.hits == 2'd0) ? {first_row, col_idx} : acc.code;

    always_comb begin
        frame_res = RES_MULTI;
        if (sat_hits == 2'd0) begin
            frame_res = RES_NONE;
        end else if (sat_hits == 2'd1) begin
            frame_res = RES_SINGLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst || frame_end) begin
            acc <= '0;
        end else if (tick) begin
            acc.hits <= sat_hits;
            acc.code <= merged_code;
        end
    end

    // Debounce FSM, advanced only at frame end.
    kp_state_t       state, state_nxt;
    logic [DB_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]      cand, cand_nxt;
    logic [3:0]      key_code_nxt;
    logic            key_valid_nxt;
    logic            key_held_nxt;

    assign cnt_inc = cnt + DB_W'(1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cand_nxt      = cand;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;

        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        cand_nxt  = merged_code;
                        cnt_nxt   = DB_W'(1);
                        state_nxt = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (frame_res == RES_SINGLE && merged_code == cand) begin
                        if (cnt_inc == DB_W'(DEBOUNCE)) begin
                            key_code_nxt  = cand;
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            cnt_nxt       = '0;
                            state_nxt     = PRESSED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        // A different key restarts from IDLE on a later frame, not this one.
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_res == RES_NONE) begin
                        cnt_nxt   = DB_W'(1);
                        state_nxt = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (frame_res == RES_NONE) begin
                        if (cnt_inc == DB_W'(DEBOUNCE)) begin
                            key_held_nxt = 1'b0;
                            cnt_nxt      = '0;
                            state_nxt    = IDLE;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = PRESSED;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
